// File: rtl/mda_pixel_shifter.sv
// -----------------------------------------------------------------------------
// mda_pixel_shifter
//
// Turns font rows into dots for the MDA video path. This block feeds the HDMI
// output port directly. Each char_load latches one 9-dot character cell.
//
// When the cell is loaded, the MDA attribute rules are resolved against it:
// blank, reverse, underline, intensity, blink and cursor. The 9 dots are then
// shifted out one per dot clock.
//
// hsync, vsync and display_enable go through a delay line with the same depth
// as the dot path. All five outputs therefore leave this block cycle-aligned.
//
// Ports
//   clk            dot clock, rising edge
//   reset          synchronous, active-high
//   char_load      strobe: sample char_code/char_bits/attr/scanline/cursor_here
//   char_code[7:0] character code of the cell
//   char_bits[7:0] font row, bit7 = leftmost dot
//   attr[7:0]      MDA attribute byte
//   scanline[3:0]  scanline within the character row
//   cursor_here    cursor is at this cell and on this scanline
//   hsync_in       raw horizontal sync from the CRTC
//   vsync_in       raw vertical sync from the CRTC
//   de_in          raw display enable from the CRTC
//   video          dot on/off
//   intensity      high-intensity dot
//   hsync          aligned hsync
//   vsync          aligned vsync
//   display_enable aligned display enable
//
// Pipeline timing (input sampled at edge N)
//   edge N    : cell_reg, cnt_reg and the first sync/de stage
//   edge N+1  : dot_reg and the second sync/de stage
//   edge N+2  : output registers
// -----------------------------------------------------------------------------
module mda_pixel_shifter #(
    parameter bit         LINE_GFX_9TH = 1'b1,
    parameter bit         BLINK_EN     = 1'b1,
    parameter logic [3:0] UL_ROW       = 4'd12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_load,
    input  logic [7:0] char_code,
    input  logic [7:0] char_bits,
    input  logic [7:0] attr,
    input  logic [3:0] scanline,
    input  logic       cursor_here,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    output logic       video,
    output logic       intensity,
    output logic       hsync,
    output logic       vsync,
    output logic       display_enable
);

    localparam logic [3:0] CNT_IDLE = 4'd9;

    logic [8:0] cell_reg;
    logic       int_en_reg;
    logic [3:0] cnt_reg;
    logic [4:0] frame_cnt_reg;
    logic       dot_reg;
    logic       int_dot_reg;
    logic       hs_d1_reg, hs_d2_reg;
    logic       vs_d1_reg, vs_d2_reg;
    logic       de_d1_reg, de_d2_reg;

    logic [8:0] base_dots;
    logic [8:0] cell_next;
    logic [7:0] attr_masked;
    logic       vsync_rise;

    // Only the top three code bits select the line-graphics range.
    logic unused_code_bits;
    assign unused_code_bits = ^char_code[4:0];

    // Dot i of the cell is font bit 7-i (leftmost dot first).
    for (genvar gi = 0; gi < 8; gi++) begin : g_dot_map
        assign base_dots[gi] = char_bits[7-gi];
    end

    // Codes 0xC0-0xDF extend their rightmost font dot into the 9th column so
    // that box-drawing characters join up across cells.
    assign base_dots[8] = (LINE_GFX_9TH && (char_code[7:5] == 3'b110)) ? char_bits[0] : 1'b0;

    assign attr_masked = attr & 8'h77;

    // vs_d1_reg holds the previous vsync_in sample, so it doubles as the edge
    // detector.
    assign vsync_rise = vsync_in & ~vs_d1_reg;

    // All attribute effects are resolved once, at load time. frame_cnt_reg
    // still holds the pre-increment value if a vsync edge coincides with
    // the load.
    always_comb begin
        cell_next = base_dots;
        if (attr_masked == 8'h00) begin
            cell_next = 9'h000;
        end else if (attr_masked == 8'h70) begin
            cell_next = ~base_dots;
        end else if ((attr[2:0] == 3'b001) && (scanline == UL_ROW)) begin
            cell_next = 9'h1FF;
        end
        if (BLINK_EN && attr[7] && !frame_cnt_reg[4]) begin
            cell_next = 9'h000;
        end
        // The cursor is applied last, so it shows through blank and blink.
        if (cursor_here && frame_cnt_reg[3]) begin
            cell_next = 9'h1FF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_reg       <= '0;
            int_en_reg     <= 1'b0;
            cnt_reg        <= CNT_IDLE;
            frame_cnt_reg  <= '0;
            dot_reg        <= 1'b0;
            int_dot_reg    <= 1'b0;
            hs_d1_reg      <= 1'b0;
            hs_d2_reg      <= 1'b0;
            vs_d1_reg      <= 1'b0;
            vs_d2_reg      <= 1'b0;
            de_d1_reg      <= 1'b0;
            de_d2_reg      <= 1'b0;
            video          <= 1'b0;
            intensity      <= 1'b0;
            hsync          <= 1'b0;
            vsync          <= 1'b0;
            display_enable <= 1'b0;
        end else begin
            // Sync / display-enable delay line.
            hs_d1_reg      <= hsync_in;
            hs_d2_reg      <= hs_d1_reg;
            hsync          <= hs_d2_reg;
            vs_d1_reg      <= vsync_in;
            vs_d2_reg      <= vs_d1_reg;
            vsync          <= vs_d2_reg;
            de_d1_reg      <= de_in;
            de_d2_reg      <= de_d1_reg;
            display_enable <= de_d2_reg;

            if (vsync_rise) begin
                frame_cnt_reg <= frame_cnt_reg + 5'd1;
            end

            // A new load always restarts at dot 0, even mid-cell.
            if (char_load) begin
                cell_reg   <= cell_next;
                int_en_reg <= attr[3];
                cnt_reg    <= 4'd0;
            end else if (cnt_reg != CNT_IDLE) begin
                cnt_reg <= cnt_reg + 4'd1;
            end

            // Dot select stage. The counter parks at 9 when idle, which
            // produces dark dots.
            if (cnt_reg != CNT_IDLE) begin
                dot_reg     <= cell_reg[cnt_reg];
                int_dot_reg <= cell_reg[cnt_reg] & int_en_reg;
            end else begin
                dot_reg     <= 1'b0;
                int_dot_reg <= 1'b0;
            end

            // Output stage. Blanking masks the dots but does not stall the
            // counter.
            video     <= dot_reg & de_d2_reg;
            intensity <= int_dot_reg & de_d2_reg;
        end
    end

endmodule

// File: tb/tb_mda_pixel_shifter.sv
module tb_mda_pixel_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic       char_load;
    logic [7:0] char_code;
    logic [7:0] char_bits;
    logic [7:0] attr;
    logic [3:0] scanline;
    logic       cursor_here;
    logic       hsync_in;
    logic       vsync_in;
    logic       de_in;
    logic       video;
    logic       intensity;
    logic       hsync;
    logic       vsync;
    logic       display_enable;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mda_pixel_shifter #(
        .LINE_GFX_9TH(1'b1),
        .BLINK_EN    (1'b1),
        .UL_ROW      (4'd12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .char_load     (char_load),
        .char_code     (char_code),
        .char_bits     (char_bits),
        .attr          (attr),
        .scanline      (scanline),
        .cursor_here   (cursor_here),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .de_in         (de_in),
        .video         (video),
        .intensity     (intensity),
        .hsync         (hsync),
        .vsync         (vsync),
        .display_enable(display_enable)
    );

    // ev/ei: bit i = expected video/intensity for dot i.
    typedef struct {
        logic [7:0] code;
        logic [7:0] bits;
        logic [7:0] at;
        logic [3:0] sl;
        logic       cur;
        logic [8:0] ev;
        logic [8:0] ei;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] code, input logic [7:0] bits, input logic [7:0] at,
                        input logic [3:0] sl, input logic cur);
        char_load   = 1'b1;
        char_code   = code;
        char_bits   = bits;
        attr        = at;
        scanline    = sl;
        cursor_here = cur;
        tick();
        char_load   = 1'b0;
        cursor_here = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        vecs[0]  = '{8'h41, 8'hAA, 8'h07, 4'd0,  1'b0, 9'h055, 9'h000};
        vecs[1]  = '{8'hC4, 8'hFF, 8'h0F, 4'd0,  1'b0, 9'h1FF, 9'h1FF};
        vecs[2]  = '{8'h41, 8'hFF, 8'h0F, 4'd0,  1'b0, 9'h0FF, 9'h0FF};
        vecs[3]  = '{8'h41, 8'h0F, 8'h70, 4'd0,  1'b0, 9'h10F, 9'h000};
        vecs[4]  = '{8'h41, 8'h00, 8'h01, 4'd12, 1'b0, 9'h1FF, 9'h000};
        vecs[5]  = '{8'h41, 8'h00, 8'h01, 4'd11, 1'b0, 9'h000, 9'h000};
        vecs[6]  = '{8'h41, 8'hFF, 8'h00, 4'd0,  1'b0, 9'h000, 9'h000};
        vecs[7]  = '{8'h41, 8'hFF, 8'h08, 4'd0,  1'b0, 9'h000, 9'h000};
        vecs[8]  = '{8'hC0, 8'h01, 8'h07, 4'd0,  1'b0, 9'h180, 9'h000};
        vecs[9]  = '{8'hDF, 8'h01, 8'h07, 4'd0,  1'b0, 9'h180, 9'h000};
        vecs[10] = '{8'hE4, 8'h01, 8'h07, 4'd0,  1'b0, 9'h080, 9'h000};
        vecs[11] = '{8'hBF, 8'h01, 8'h07, 4'd0,  1'b0, 9'h080, 9'h000};
        vecs[12] = '{8'h41, 8'hFF, 8'h87, 4'd0,  1'b0, 9'h000, 9'h000};
        vecs[13] = '{8'h41, 8'h00, 8'h09, 4'd12, 1'b0, 9'h1FF, 9'h1FF};
        vecs[14] = '{8'h41, 8'h3C, 8'h0F, 4'd0,  1'b0, 9'h03C, 9'h03C};

        reset = 1'b1; char_load = 1'b0; char_code = '0; char_bits = '0; attr = '0;
        scanline = '0; cursor_here = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;

        // Reset state, then idle after release.
        repeat (4) tick();
        chk("reset_video", video, 0);
        chk("reset_intensity", intensity, 0);
        chk("reset_hsync", hsync, 0);
        chk("reset_vsync", vsync, 0);
        chk("reset_de", display_enable, 0);
        reset = 1'b0;
        repeat (9) tick();
        chk("idle_video", video, 0);
        $display("seq reset/idle done");

        // Table-driven cells (frame 0: cursor and blink phases both off).
        de_in = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NVEC; i++) begin
            load(vecs[i].code, vecs[i].bits, vecs[i].at, vecs[i].sl, vecs[i].cur);
            tick();
            for (int k = 0; k < 9; k++) begin
                tick();
                chk($sformatf("vec%0d_video_dot%0d", i, k), video, vecs[i].ev[k]);
                chk($sformatf("vec%0d_int_dot%0d", i, k), intensity, vecs[i].ei[k]);
            end
            tick();
            chk($sformatf("vec%0d_idle", i), video, 0);
            $display("vec %0d code=%h bits=%h attr=%h sl=%0d done", i, vecs[i].code,
                     vecs[i].bits, vecs[i].at, vecs[i].sl);
        end

        // A load during dot 2 aborts the cell: A dots 0..2, then B from dot 0.
        load(8'h41, 8'hFF, 8'h07, 4'd0, 1'b0);
        tick(); tick();
        load(8'h41, 8'h00, 8'h07, 4'd0, 1'b0);
        chk("abort_a_dot1", video, 1);
        tick();
        chk("abort_a_dot2", video, 1);
        tick();
        chk("abort_b_dot0", video, 0);
        repeat (10) tick();
        $display("seq abort done");

        // de_in low only at the load edge blanks dot 0 only.
        de_in = 1'b0;
        load(8'h41, 8'hFF, 8'h07, 4'd0, 1'b0);
        de_in = 1'b1;
        tick(); tick();
        chk("de_blank_dot0", video, 0);
        tick();
        chk("de_blank_dot1", video, 1);
        repeat (10) tick();
        $display("seq de blanking done");

        // Reset coinciding with char_load: reset wins, so no dots appear.
        reset = 1'b1;
        load(8'hC4, 8'hFF, 8'h0F, 4'd0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("reset_load_video%0d", k), video, 0);
        end
        $display("seq reset+load done");

        // Frame sweep from frame 0. Each blink-cell load coincides with the
        // vsync_in rising edge, so it must use the pre-increment frame count.
        do_reset();
        for (int f = 0; f < 32; f++) begin
            load(8'h41, 8'h00, 8'h07, 4'd0, 1'b1);
            tick(); tick();
            chk($sformatf("cursor_frame%0d", f), video, ((f / 8) % 2 == 1) ? 1 : 0);
            vsync_in = 1'b1;
            load(8'h41, 8'hFF, 8'h87, 4'd0, 1'b0);
            vsync_in = 1'b0;
            tick(); tick();
            chk($sformatf("blink_frame%0d", f), video, (f >= 16) ? 1 : 0);
            repeat (8) tick();
            $display("frame %0d done", f);
        end

        // Sync and display-enable latency: changes sampled at edge N appear at N+2.
        hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
        tick();
        chk("hsync_n", hsync, 0);
        chk("vsync_n", vsync, 0);
        chk("de_n", display_enable, 1);
        tick();
        chk("hsync_n1", hsync, 0);
        chk("vsync_n1", vsync, 0);
        chk("de_n1", display_enable, 1);
        tick();
        chk("hsync_n2", hsync, 1);
        chk("vsync_n2", vsync, 1);
        chk("de_n2", display_enable, 0);
        $display("seq sync latency done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
